multi_class_sum: RTL and testbench

MULTI_CLASS_SUM -- requirements
Module: multi_class_sum

---
 rtl/tm_pkg.sv | 34 +++
 rtl/clause_vote_diff.sv | 19 +
 rtl/multi_class_sum.sv | 96 +++++++++
 tb/tb_multi_class_sum.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tm_pkg.sv
// Shared types and helpers for the class-sum accumulator: FSM states,
// saturation helper and width functions.
package tm_pkg;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    ARGMAX = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Wide enough for any SUM_W (<=32) plus one guard bit, so add+clamp never wraps.
  localparam int WIDE_W = 33;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Signed delta width covering -clauses/2..+clauses/2.
  function automatic int delta_w(input int clauses);
    return $clog2(clauses / 2) + 2;
  endfunction

  function automatic logic signed [WIDE_W-1:0] clamp_sum(
    input logic signed [WIDE_W-1:0] v,
    input int                       t
  );
    logic signed [WIDE_W-1:0] lim;
    lim = WIDE_W'(t);
    if (v > lim)  return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/clause_vote_diff.sv
// Per-class vote difference: even-index clauses vote for, odd-index vote against.
module clause_vote_diff
  import tm_pkg::*;
#(
  parameter int CLAUSES = 32
) (
  input  logic [CLAUSES-1:0]                 votes,
  output logic signed [delta_w(CLAUSES)-1:0] delta
);

  localparam int DW = delta_w(CLAUSES);

  always_comb begin
    delta = '0;
    for (int i = 0; i < CLAUSES; i++)
      if (votes[i]) delta = i[0] ? delta - DW'(1) : delta + DW'(1);
  end

endmodule

// File: rtl/multi_class_sum.sv
// Accumulates saturating per-class vote sums over a sample of beats, then
// scans the classes one per cycle to find the winner.
module multi_class_sum
  import tm_pkg::*;
#(
  parameter int NUM_CLASSES = 4,
  parameter int CLAUSES     = 32,
  parameter int SUM_W       = 16,
  parameter int CLAMP_T     = 2**(SUM_W-1)-1
) (
  input  logic                           clk,
  input  logic                           rst_flag,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [NUM_CLASSES*CLAUSES-1:0] clause_output,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_CLASSES*SUM_W-1:0]   class_sums,
  output logic [$clog2(NUM_CLASSES)-1:0] pred_class,
  output logic [SUM_W-1:0]               pred_sum
);

  localparam int IW = $clog2(NUM_CLASSES);
  localparam int DW = delta_w(CLAUSES);

  state_e                             state;
  logic [NUM_CLASSES-1:0][SUM_W-1:0]  sums;
  logic [NUM_CLASSES-1:0][SUM_W-1:0]  nxt_sum;
  logic [NUM_CLASSES-1:0][DW-1:0]     delta;
  logic [IW-1:0]                      cnt;
  logic [IW-1:0]                      best_idx;
  logic [SUM_W-1:0]                   best_sum;

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
    logic signed [WIDE_W-1:0] wide;

    clause_vote_diff #(.CLAUSES(CLAUSES)) u_vote (
      .votes (clause_output[c*CLAUSES +: CLAUSES]),
      .delta (delta[c])
    );

    assign wide       = clamp_sum(WIDE_W'($signed(sums[c])) + WIDE_W'($signed(delta[c])), CLAMP_T);
    assign nxt_sum[c] = wide[SUM_W-1:0];
  end

  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      state     <= ACCUM;
      sums      <= '0;
      cnt       <= '0;
      best_idx  <= '0;
      best_sum  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            sums <= nxt_sum;
            if (in_last) begin
              state <= ARGMAX;
              cnt   <= '0;
            end
          end
        end
        ARGMAX: begin
          // Class 0 seeds the best; later classes need a strict win so ties keep the lower index.
          if (cnt == '0 || $signed(sums[cnt]) > $signed(best_sum)) begin
            best_idx <= cnt;
            best_sum <= sums[cnt];
          end
          if (cnt == IW'(NUM_CLASSES-1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCUM;
            out_valid <= 1'b0;
            sums      <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign in_ready   = (state == ACCUM);
  assign class_sums = sums;
  assign pred_class = best_idx;
  assign pred_sum   = best_sum;

endmodule

// File: tb/tb_multi_class_sum.sv
// Directed bench for multi_class_sum at 4 classes x 32 clauses, 8-bit sums, clamp 100.
module tb_multi_class_sum;

  localparam int NC = 4;
  localparam int CL = 32;
  localparam int SW = 8;
  localparam int CT = 100;

  logic              clk = 1'b0;
  logic              rst_flag;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [NC*CL-1:0]  clause_output;
  logic              out_valid;
  logic              out_ready;
  logic [NC*SW-1:0]  class_sums;
  logic [1:0]        pred_class;
  logic [SW-1:0]     pred_sum;

  int errs   = 0;
  int checks = 0;

  multi_class_sum #(
    .NUM_CLASSES (NC),
    .CLAUSES     (CL),
    .SUM_W       (SW),
    .CLAMP_T     (CT)
  ) dut (
    .clk           (clk),
    .rst_flag      (rst_flag),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_last       (in_last),
    .clause_output (clause_output),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .class_sums    (class_sums),
    .pred_class    (pred_class),
    .pred_sum      (pred_sum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NC*CL-1:0] pack4(input logic [31:0] c0, input logic [31:0] c1,
                                             input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  task automatic beat(input logic [NC*CL-1:0] v, input logic last);
    clause_output = v;
    in_valid      = 1'b1;
    in_last       = last;
    @(posedge clk); #1;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    clause_output = '0;
  endtask

  // Cycle 1 is the cycle right after the in_last handshake edge.
  task automatic wait_out(output int n);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int  n;
    bit  seen;

    rst_flag      = 1'b1;
    in_valid      = 1'b0;
    in_last       = 1'b0;
    out_ready     = 1'b0;
    clause_output = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sums", class_sums, 0);
    chk("rst_pred_class", pred_class, 0);
    chk("rst_pred_sum", pred_sum, 0);
    rst_flag = 1'b0;
    @(posedge clk); #1;

    // Class 0 all-even votes: +16 per beat, 3 beats
    beat(pack4(32'h55555555, 0, 0, 0), 1'b0);
    chk("live_sum_1beat", class_sums, 32'h00000010);
    beat(pack4(32'h55555555, 0, 0, 0), 1'b0);
    beat(pack4(32'h55555555, 0, 0, 0), 1'b1);
    chk("argmax_in_ready", in_ready, 0);
    wait_out(n);
    chk("t1_latency", n, 5);
    chk("t1_out_valid", out_valid, 1);
    chk("t1_pred_class", pred_class, 0);
    chk("t1_pred_sum", pred_sum, 48);
    chk("t1_sums", class_sums, 32'h00000030);
    take();
    chk("t1_clear_sums", class_sums, 0);
    chk("t1_clear_ready", in_ready, 1);

    // Saturation both ways: class2 +128 -> 100, class3 -128 -> -100
    for (int i = 0; i < 8; i++)
      beat(pack4(0, 0, 32'h55555555, 32'hAAAAAAAA), (i == 7));
    wait_out(n);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_sums", class_sums, 32'h9C640000);
    chk("t2_pred_class", pred_class, 2);
    chk("t2_pred_sum", pred_sum, 32'h64);
    take();

    // Tie between class1 and class3 at +16; class0 -4, class2 cancels to 0
    beat(pack4(32'h000000AA, 32'h55555555, 32'h00000003, 32'h55555555), 1'b1);
    wait_out(n);
    chk("t3_latency", n, 5);
    chk("t3_sums", class_sums, 32'h100010FC);
    chk("t3_pred_class", pred_class, 1);
    chk("t3_pred_sum", pred_sum, 16);

    // Stall in DONE with beats offered: everything holds, beats are ignored
    clause_output = '1;
    in_valid      = 1'b1;
    in_last       = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_sums", class_sums, 32'h100010FC);
      chk("stall_pred", {pred_class, pred_sum}, {2'd1, 8'd16});
    end
    in_valid      = 1'b0;
    in_last       = 1'b0;
    clause_output = '0;
    take();
    chk("t4_clear_sums", class_sums, 0);
    chk("t4_clear_ready", in_ready, 1);
    chk("t4_out_valid", out_valid, 0);

    // Reset in the 2nd ARGMAX cycle aborts the sample
    beat(pack4(32'h55555555, 0, 0, 0), 1'b1);
    @(posedge clk); #1;
    chk("t5_in_argmax", in_ready, 0);
    rst_flag = 1'b1;
    #2;
    chk("t5_rst_sums", class_sums, 0);
    chk("t5_rst_ready", in_ready, 1);
    chk("t5_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst_flag = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("t5_no_result", seen, 0);
    chk("t5_ready_after", in_ready, 1);
    chk("t5_pred_sum", pred_sum, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
